// File: rtl/ami_qos_channel_arbiter.sv
// ---------------------------------------------------------------------------
// ami_qos_channel_arbiter
//
// Per-memory-channel arbiter. Apps compete for one memory-interface request
// register using weighted round-robin: each app holds a credit count that is
// reloaded from its weight once no eligible app has credit left. Reads are
// capped per app by an outstanding counter, and responses are routed back to
// the app named by mem_resp_app with no buffering.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   app_enable        per-app arbitration enable (clearing it drains the app)
//   cfg_weight        per-app weight, slice i = app i
//   req_valid/req_is_write/req_payload   per-app request inputs
//   req_grant         one-hot (or zero) accept strobe back to the apps
//   mem_req_*         registered request towards the memory interface
//   mem_resp_*        response from the memory interface
//   resp_valid/resp_payload/resp_grant   per-app response handshake
//   outstanding       in-flight read count per app, slice i = app i
//   drain_done        app disabled with nothing in flight
//   err_underflow     sticky: response arrived for an app with zero in flight
// ---------------------------------------------------------------------------
module ami_qos_channel_arbiter #(
  parameter int NUM_APPS        = 4,
  parameter int APP_BITS        = $clog2(NUM_APPS),
  parameter int REQ_W           = 576,
  parameter int RESP_W          = 512,
  parameter int WEIGHT_W        = 4,
  parameter int MAX_OUTSTANDING = 32,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_APPS-1:0]          app_enable,
  input  logic [NUM_APPS*WEIGHT_W-1:0] cfg_weight,
  input  logic [NUM_APPS-1:0]          req_valid,
  input  logic [NUM_APPS-1:0]          req_is_write,
  input  logic [NUM_APPS*REQ_W-1:0]    req_payload,
  output logic [NUM_APPS-1:0]          req_grant,
  output logic                         mem_req_valid,
  output logic [REQ_W-1:0]             mem_req_payload,
  output logic                         mem_req_is_write,
  output logic [APP_BITS-1:0]          mem_req_app,
  input  logic                         mem_req_grant,
  input  logic                         mem_resp_valid,
  input  logic [RESP_W-1:0]            mem_resp_payload,
  input  logic [APP_BITS-1:0]          mem_resp_app,
  output logic                         mem_resp_grant,
  output logic [NUM_APPS-1:0]          resp_valid,
  output logic [RESP_W-1:0]            resp_payload,
  input  logic [NUM_APPS-1:0]          resp_grant,
  output logic [NUM_APPS*CNT_W-1:0]    outstanding,
  output logic [NUM_APPS-1:0]          drain_done,
  output logic                         err_underflow
);

  logic [WEIGHT_W-1:0] credit_q [NUM_APPS];
  logic [WEIGHT_W-1:0] credit_d [NUM_APPS];
  logic [CNT_W-1:0]    out_q    [NUM_APPS];
  logic [CNT_W-1:0]    out_d    [NUM_APPS];
  logic [APP_BITS-1:0] ptr_q, ptr_d;
  logic                err_q, err_d;
  logic                mvalid_q, mvalid_d;
  logic [REQ_W-1:0]    mpay_q, mpay_d;
  logic                mwr_q, mwr_d;
  logic [APP_BITS-1:0] mapp_q, mapp_d;

  logic                can_load;
  logic [NUM_APPS-1:0] elig, credited, cand;
  logic                any_credited;
  logic                found_lo, found_hi, gnt_en;
  logic [APP_BITS-1:0] win_lo, win_hi, win;
  logic [NUM_APPS-1:0] hs, inc;
  logic [WEIGHT_W-1:0] wt;

  // Response path: purely combinational routing by app ID. An ID outside
  // 0..NUM_APPS-1 matches no app, so it is never accepted.
  always_comb begin
    resp_valid = '0;
    for (int unsigned i = 0; i < NUM_APPS; i++) begin
      resp_valid[i] = mem_resp_valid & (mem_resp_app == APP_BITS'(i));
    end
    hs             = resp_valid & resp_grant;
    mem_resp_grant = |hs;
    resp_payload   = mem_resp_payload;
  end

  // Arbitration
  always_comb begin
    can_load = ~mvalid_q | mem_req_grant;
    elig     = '0;
    credited = '0;
    for (int unsigned i = 0; i < NUM_APPS; i++) begin
      elig[i]     = req_valid[i] & app_enable[i] &
                    (req_is_write[i] | (out_q[i] < CNT_W'(MAX_OUTSTANDING)));
      credited[i] = elig[i] & (credit_q[i] != '0);
    end
    any_credited = |credited;
    // With no credited candidate the grant comes from a same-cycle reload,
    // so the candidate set widens to every eligible app.
    cand = any_credited ? credited : elig;

    // Scan from ptr+1 with wrap: lowest candidate above the pointer wins,
    // otherwise the lowest candidate overall.
    found_lo = 1'b0;
    found_hi = 1'b0;
    win_lo   = '0;
    win_hi   = '0;
    for (int unsigned i = 0; i < NUM_APPS; i++) begin
      if (cand[i] && !found_lo) begin
        found_lo = 1'b1;
        win_lo   = APP_BITS'(i);
      end
      if (cand[i] && !found_hi && (APP_BITS'(i) > ptr_q)) begin
        found_hi = 1'b1;
        win_hi   = APP_BITS'(i);
      end
    end
    win    = found_hi ? win_hi : win_lo;
    gnt_en = can_load & found_lo & ~rst;

    req_grant = '0;
    if (gnt_en) req_grant[win] = 1'b1;
  end

  // Next state
  always_comb begin
    credit_d = credit_q;
    out_d    = out_q;
    ptr_d    = ptr_q;
    err_d    = err_q;
    mvalid_d = mvalid_q;
    mpay_d   = mpay_q;
    mwr_d    = mwr_q;
    mapp_d   = mapp_q;
    inc      = '0;
    wt       = '0;

    if (gnt_en) begin
      if (!any_credited) begin
        for (int unsigned i = 0; i < NUM_APPS; i++) begin
          wt          = cfg_weight[i*WEIGHT_W +: WEIGHT_W];
          credit_d[i] = (wt == '0) ? WEIGHT_W'(1) : wt;
        end
      end
      credit_d[win] = credit_d[win] - WEIGHT_W'(1);
      ptr_d    = win;
      mvalid_d = 1'b1;
      mapp_d   = win;
      for (int unsigned i = 0; i < NUM_APPS; i++) begin
        if (win == APP_BITS'(i)) begin
          mpay_d = req_payload[i*REQ_W +: REQ_W];
          mwr_d  = req_is_write[i];
          inc[i] = ~req_is_write[i];
        end
      end
    end else if (mem_req_grant) begin
      mvalid_d = 1'b0;
    end

    for (int unsigned i = 0; i < NUM_APPS; i++) begin
      if (inc[i] && !hs[i]) begin
        out_d[i] = out_q[i] + CNT_W'(1);
      end else if (!inc[i] && hs[i]) begin
        if (out_q[i] == '0) err_d = 1'b1;
        else                out_d[i] = out_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_APPS; i++) begin
        credit_q[i] <= '0;
        out_q[i]    <= '0;
      end
      ptr_q    <= '0;
      err_q    <= 1'b0;
      mvalid_q <= 1'b0;
      mpay_q   <= '0;
      mwr_q    <= 1'b0;
      mapp_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_APPS; i++) begin
        credit_q[i] <= credit_d[i];
        out_q[i]    <= out_d[i];
      end
      ptr_q    <= ptr_d;
      err_q    <= err_d;
      mvalid_q <= mvalid_d;
      mpay_q   <= mpay_d;
      mwr_q    <= mwr_d;
      mapp_q   <= mapp_d;
    end
  end

  always_comb begin
    outstanding = '0;
    drain_done  = '0;
    for (int unsigned i = 0; i < NUM_APPS; i++) begin
      outstanding[i*CNT_W +: CNT_W] = out_q[i];
      drain_done[i] = ~app_enable[i] & (out_q[i] == '0);
    end
  end

  assign mem_req_valid    = mvalid_q;
  assign mem_req_payload  = mpay_q;
  assign mem_req_is_write = mwr_q;
  assign mem_req_app      = mapp_q;
  assign err_underflow    = err_q;

endmodule

// File: tb/tb_ami_qos_channel_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ami_qos_channel_arbiter
//
// Drives the arbiter with directed phases followed by a randomized phase and
// compares every output, every cycle, against a behavioural model of the
// weighted round-robin / outstanding-count rules.
// ---------------------------------------------------------------------------
module tb_ami_qos_channel_arbiter;
  localparam int NA   = 4;
  localparam int AB   = 2;
  localparam int RW   = 32;
  localparam int PW   = 32;
  localparam int WW   = 4;
  localparam int MAXO = 4;
  localparam int CW   = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [NA-1:0]    app_enable;
  logic [NA*WW-1:0] cfg_weight;
  logic [NA-1:0]    req_valid;
  logic [NA-1:0]    req_is_write;
  logic [NA*RW-1:0] req_payload;
  logic [NA-1:0]    req_grant;
  logic             mem_req_valid;
  logic [RW-1:0]    mem_req_payload;
  logic             mem_req_is_write;
  logic [AB-1:0]    mem_req_app;
  logic             mem_req_grant;
  logic             mem_resp_valid;
  logic [PW-1:0]    mem_resp_payload;
  logic [AB-1:0]    mem_resp_app;
  logic             mem_resp_grant;
  logic [NA-1:0]    resp_valid;
  logic [PW-1:0]    resp_payload;
  logic [NA-1:0]    resp_grant;
  logic [NA*CW-1:0] outstanding;
  logic [NA-1:0]    drain_done;
  logic             err_underflow;

  always #5 clk = ~clk;

  ami_qos_channel_arbiter #(
    .NUM_APPS(NA), .APP_BITS(AB), .REQ_W(RW), .RESP_W(PW),
    .WEIGHT_W(WW), .MAX_OUTSTANDING(MAXO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .app_enable(app_enable), .cfg_weight(cfg_weight),
    .req_valid(req_valid), .req_is_write(req_is_write), .req_payload(req_payload),
    .req_grant(req_grant), .mem_req_valid(mem_req_valid),
    .mem_req_payload(mem_req_payload), .mem_req_is_write(mem_req_is_write),
    .mem_req_app(mem_req_app), .mem_req_grant(mem_req_grant),
    .mem_resp_valid(mem_resp_valid), .mem_resp_payload(mem_resp_payload),
    .mem_resp_app(mem_resp_app), .mem_resp_grant(mem_resp_grant),
    .resp_valid(resp_valid), .resp_payload(resp_payload), .resp_grant(resp_grant),
    .outstanding(outstanding), .drain_done(drain_done), .err_underflow(err_underflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model state
  int          m_cred [NA];
  int          m_out  [NA];
  int          m_ptr;
  bit          m_valid;
  logic [RW-1:0] m_pay;
  bit          m_wr;
  int          m_app;
  bit          m_err;
  int          gcnt [NA];

  function automatic bit is_elig(input int a);
    return req_valid[a] && app_enable[a] && (req_is_write[a] || m_out[a] < MAXO);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NA; i++) begin m_cred[i] = 0; m_out[i] = 0; end
    m_ptr = 0; m_valid = 0; m_pay = '0; m_wr = 0; m_app = 0; m_err = 0;
  endtask

  task automatic clr_gcnt();
    for (int i = 0; i < NA; i++) gcnt[i] = 0;
  endtask

  task automatic rand_payloads();
    for (int i = 0; i < NA; i++) req_payload[i*RW +: RW] = $urandom();
    mem_resp_payload = $urandom();
  endtask

  // Called at a negedge with inputs already applied; returns at the next negedge.
  task automatic step();
    int w, a, wt, n, hs_app;
    bit rel, can_load;
    logic [NA-1:0]    eg, ev;
    logic [NA*CW-1:0] eo;
    logic [NA-1:0]    ed;
    #1;
    w = -1; rel = 0;
    can_load = !rst && (!m_valid || mem_req_grant);
    if (can_load) begin
      for (int k = 1; k <= NA; k++) begin
        a = (m_ptr + k) % NA;
        if (w < 0 && is_elig(a) && m_cred[a] > 0) w = a;
      end
      if (w < 0) begin
        for (int k = 1; k <= NA; k++) begin
          a = (m_ptr + k) % NA;
          if (w < 0 && is_elig(a)) begin w = a; rel = 1; end
        end
      end
    end
    eg = '0; if (w >= 0) eg[w] = 1'b1;
    ev = '0; if (mem_resp_valid) ev[mem_resp_app] = 1'b1;
    eo = '0; ed = '0;
    for (int i = 0; i < NA; i++) begin
      eo[i*CW +: CW] = CW'(m_out[i]);
      ed[i] = !app_enable[i] && m_out[i] == 0;
    end
    check_eq("req_grant", req_grant, eg);
    check_eq("mem_req_valid", mem_req_valid, m_valid);
    check_eq("mem_req_payload", mem_req_payload, m_pay);
    check_eq("mem_req_is_write", mem_req_is_write, m_wr);
    check_eq("mem_req_app", mem_req_app, m_app);
    check_eq("resp_valid", resp_valid, ev);
    check_eq("resp_payload", resp_payload, mem_resp_payload);
    check_eq("mem_resp_grant", mem_resp_grant, mem_resp_valid && resp_grant[mem_resp_app]);
    check_eq("outstanding", outstanding, eo);
    check_eq("drain_done", drain_done, ed);
    check_eq("err_underflow", err_underflow, m_err);
    for (int i = 0; i < NA; i++) if (req_grant[i]) gcnt[i]++;

    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      hs_app = (mem_resp_valid && resp_grant[mem_resp_app]) ? int'(mem_resp_app) : -1;
      for (int i = 0; i < NA; i++) begin
        n = m_out[i] + ((w == i && !req_is_write[i]) ? 1 : 0) - ((hs_app == i) ? 1 : 0);
        if (n < 0) begin n = 0; m_err = 1; end
        m_out[i] = n;
      end
      if (w >= 0) begin
        if (rel) begin
          for (int i = 0; i < NA; i++) begin
            wt = int'(cfg_weight[i*WW +: WW]);
            m_cred[i] = (wt < 1) ? 1 : wt;
          end
        end
        m_cred[w]--;
        m_ptr   = w;
        m_valid = 1;
        m_pay   = req_payload[w*RW +: RW];
        m_wr    = req_is_write[w];
        m_app   = w;
      end else if (mem_req_grant) begin
        m_valid = 0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1; app_enable = '0; cfg_weight = '0; req_valid = '0; req_is_write = '0;
    req_payload = '0; mem_req_grant = 0; mem_resp_valid = 0; mem_resp_payload = '0;
    mem_resp_app = '0; resp_grant = '0;
    model_reset(); clr_gcnt();
    @(negedge clk);
    repeat (2) step();
    rst = 0;
    step();
    check_eq("reset_drain_all", drain_done, 4'hF);
    check_eq("reset_mreq_valid", mem_req_valid, 1'b0);
    app_enable = 4'hF;
    step();
    check_eq("enabled_drain_none", drain_done, 4'h0);

    // Weighted share: weights 3,1,1,1, all apps writing continuously
    cfg_weight = {4'd1, 4'd1, 4'd1, 4'd3};
    req_valid = 4'hF; req_is_write = 4'hF; mem_req_grant = 1;
    clr_gcnt();
    repeat (60) begin rand_payloads(); step(); end
    check_eq("wrr_app0", gcnt[0], 30);
    check_eq("wrr_app1", gcnt[1], 10);
    check_eq("wrr_app2", gcnt[2], 10);
    check_eq("wrr_app3", gcnt[3], 10);
    req_valid = '0;
    step();

    // Backpressure: app0 alone, memory stalled for 10 cycles then released
    req_valid = 4'b0001; mem_req_grant = 0; clr_gcnt();
    repeat (10) begin rand_payloads(); step(); end
    check_eq("bp_one_grant", gcnt[0], 1);
    mem_req_grant = 1; clr_gcnt();
    repeat (5) begin rand_payloads(); step(); end
    check_eq("bp_resume_rate", gcnt[0], 5);

    // Outstanding cap: app1 reads, app2 writes, no responses
    req_valid = 4'b0110; req_is_write = 4'b1101; clr_gcnt();
    repeat (12) begin rand_payloads(); step(); end
    check_eq("cap_app1_grants", gcnt[1], MAXO);
    mem_resp_valid = 1; mem_resp_app = 2'd1; resp_grant = 4'b0010;
    step();
    mem_resp_valid = 0; resp_grant = '0;
    repeat (3) step();

    // Response stall, then read grant coinciding with response handshake
    req_valid = '0;
    mem_resp_valid = 1; mem_resp_app = 2'd2; resp_grant = 4'b1011;
    step();
    check_eq("resp_stall", mem_resp_grant, 1'b0);
    req_valid = 4'b0100; req_is_write = 4'b0000; resp_grant = 4'b0100;
    step();
    mem_resp_valid = 0; resp_grant = '0; req_valid = '0;
    step();

    // Randomized phase
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 49) == 0) cfg_weight = $urandom();
      app_enable     = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'hF;
      req_valid      = 4'($urandom());
      req_is_write   = 4'($urandom());
      mem_req_grant  = ($urandom_range(0, 3) != 0);
      mem_resp_valid = ($urandom_range(0, 2) == 0);
      mem_resp_app   = 2'($urandom());
      resp_grant     = 4'($urandom());
      rand_payloads();
      step();
    end

    // Drain and underflow on app3
    rst = 1; req_valid = '0; mem_resp_valid = 0; resp_grant = '0;
    mem_req_grant = 1; app_enable = 4'hF;
    step();
    rst = 0;
    req_valid = 4'b1000; req_is_write = 4'b0000;
    repeat (2) begin rand_payloads(); step(); end
    req_valid = '0; app_enable = 4'b0111;
    step();
    check_eq("drain_pending", drain_done[3], 1'b0);
    mem_resp_valid = 1; mem_resp_app = 2'd3; resp_grant = 4'b1000;
    repeat (2) step();
    check_eq("drain_done3", drain_done[3], 1'b1);
    check_eq("no_underflow_yet", err_underflow, 1'b0);
    step();
    mem_resp_valid = 0; resp_grant = '0;
    step();
    check_eq("underflow_set", err_underflow, 1'b1);
    check_eq("underflow_out3", outstanding[3*CW +: CW], 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
